// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, fill level and almost-full/almost-empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       write,
    input  logic                       read,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH):0]     use_dw,
    output logic                       empty_n,
    output logic                       full_n,
    output logic                       almost_empty_n,
    output logic                       almost_full_n,
    input  logic                       err_clr,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    use_dw_q, use_dw_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic is_full, is_empty, wr_acc, rd_acc, wr_rej, rd_rej;

    assign is_full  = (use_dw_q == DEPTH_C);
    assign is_empty = (use_dw_q == '0);

    // A simultaneous read frees a slot, so a full FIFO still takes the write.
    assign wr_acc = write && (!is_full || read);
    assign rd_acc = read && !is_empty;
    assign wr_rej = write && !wr_acc;
    assign rd_rej = read && !rd_acc;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        use_dw_d   = use_dw_q;
        data_out_d = data_out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   use_dw_d = use_dw_q + 1'b1;
            2'b01:   use_dw_d = use_dw_q - 1'b1;
            default: use_dw_d = use_dw_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            use_dw_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            use_dw_q   <= use_dw_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_rej) overflow_q  <= 1'b1;
            if (rd_rej) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err;
    assign unused_err = ^{err_clr, wr_rej, rd_rej};
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

    assign data_out       = data_out_q;
    assign use_dw         = use_dw_q;
    assign empty_n        = !is_empty;
    assign full_n         = !is_full;
    assign almost_empty_n = (use_dw_q > AE_C);
    assign almost_full_n  = (use_dw_q < AF_C);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=32): vector table plus fill/drain/overlap/reset sequences.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n, write, read, err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [5:0] use_dw;
    logic       empty_n, full_n, almost_empty_n, almost_full_n, overflow, underflow;

    int checks = 0;
    int errors = 0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .write(write), .read(read),
        .data_out(data_out), .use_dw(use_dw), .empty_n(empty_n), .full_n(full_n),
        .almost_empty_n(almost_empty_n), .almost_full_n(almost_full_n),
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic       rst_n, wr, rd, clr;
        logic [7:0] din, dout;
        logic [5:0] use_lvl;
        logic       en, unf;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic w, input logic r, input logic c, input logic [7:0] d);
        rst_n = rn; write = w; read = r; err_clr = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " use_dw"}, use_dw, 0);
        check({tag, " empty_n"}, empty_n, 0);
        check({tag, " full_n"}, full_n, 1);
        check({tag, " almost_empty_n"}, almost_empty_n, 0);
        check({tag, " almost_full_n"}, almost_full_n, 1);
        check({tag, " data_out"}, data_out, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " underflow"}, underflow, 0);
    endtask

    initial begin
        //               rst  wr    rd    clr   din    dout   use   en    unf
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 6'd1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 6'd2, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 6'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h22, 6'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 6'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 6'd0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 8'h33, 6'd1, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 6'd1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 6'd0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 8'h00, 6'd0, 1'b0, 1'b0};

        rst_n = 1'b0; write = 1'b0; read = 1'b0; err_clr = 1'b0; data_in = 8'h00;

        // Reset held with a write pending: reset wins.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        check_reset_state("reset");

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
            check($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
            check($sformatf("vec%0d use_dw", i), use_dw, tbl[i].use_lvl);
            check($sformatf("vec%0d empty_n", i), empty_n, tbl[i].en);
            check($sformatf("vec%0d underflow", i), underflow, tbl[i].unf & ERR);
        end

        // Fill 0x01..0x20 from reset.
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            check($sformatf("fill%0d use_dw", i), use_dw, i);
            check($sformatf("fill%0d full_n", i), full_n, (i < 32));
            check($sformatf("fill%0d almost_full_n", i), almost_full_n, (i < 28));
            check($sformatf("fill%0d almost_empty_n", i), almost_empty_n, (i > 4));
            check($sformatf("fill%0d data_out", i), data_out, 0);
        end

        // Write into a full FIFO is discarded.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        check("ovf use_dw", use_dw, 32);
        check("ovf full_n", full_n, 0);
        check("ovf overflow", overflow, ERR);

        // Drain: 0x01..0x20 in order, 0xAA never appears.
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("drain%0d data_out", i), data_out, i);
            check($sformatf("drain%0d use_dw", i), use_dw, 32 - i);
        end
        check("drain empty_n", empty_n, 0);
        check("drain almost_empty_n", almost_empty_n, 0);
        check("drain overflow sticky", overflow, ERR);

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr overflow", overflow, 0);

        // Pointers wrapped to 0: a lone write/read round-trips.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("wrap data_out", data_out, 8'h77);
        check("wrap use_dw", use_dw, 0);

        // Refill and run 10 simultaneous read+write cycles at full.
        for (int i = 1; i <= 32; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
        check("refill use_dw", use_dw, 32);
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h80 + j));
            check($sformatf("rw%0d data_out", j), data_out, j + 1);
            check($sformatf("rw%0d use_dw", j), use_dw, 32);
            check($sformatf("rw%0d overflow", j), overflow, 0);
        end

        // Set overflow, drain to 17, then reset mid-stream.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hBB);
        check("ovf2 overflow", overflow, ERR);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("mid use_dw", use_dw, 17);
        check("mid data_out", data_out, 8'h19);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hCC);
        check_reset_state("midrst");

        // Empty with read+write: only the write is taken.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        check("er use_dw", use_dw, 1);
        check("er data_out", data_out, 0);
        check("er underflow", underflow, ERR);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("er clr underflow", underflow, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("er readback", data_out, 8'h55);
        // err_clr beats a same-cycle rejected read.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        check("clr priority underflow", underflow, 0);
        check("clr priority data_out", data_out, 8'h55);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 32, number of storage words (power of two, 4..1024).
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-4, fill level at or above which almost_full_n is asserted.
REQ-004 SHALL provide parameter AE_LEVEL, default 4, fill level at or below which almost_empty_n is asserted.
REQ-005 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL provide port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL provide port data_in  input  WIDTH  write data.
REQ-008 SHALL provide port write  input  1  write request.
REQ-009 SHALL provide port read  input  1  read request.
REQ-010 SHALL provide port data_out  output  WIDTH  registered read data.
REQ-011 SHALL provide port use_dw  output  clog2(DEPTH)+1  current fill level, 0..DEPTH.
REQ-012 SHALL provide port empty_n  output  1  low when use_dw==0.
REQ-013 SHALL provide port full_n  output  1  low when use_dw==DEPTH.
REQ-014 SHALL provide port almost_empty_n  output  1  low when use_dw<=AE_LEVEL.
REQ-015 SHALL provide port almost_full_n  output  1  low when use_dw>=AF_LEVEL.
REQ-016 SHALL provide port err_clr  input  1  clears sticky error flags.
REQ-017 SHALL provide port overflow  output  1  sticky flag for a write rejected while full.
REQ-018 SHALL provide port underflow  output  1  sticky flag for a read rejected while empty.

Function
REQ-019 SHALL implement storage as a DEPTH-entry array with read and write pointers of width clog2(DEPTH), each wrapping from DEPTH-1 to 0.
REQ-020 SHALL accept a write when write=1 and (full_n=1 or read=1); accepted data is stored at wr_ptr and wr_ptr increments.
REQ-021 SHALL accept a read when read=1 and empty_n=1; data_out loads mem[rd_ptr] at that edge (1-cycle latency) and rd_ptr increments.
REQ-022 SHALL hold data_out unchanged in any cycle without an accepted read.
REQ-023 SHALL update use_dw each edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL, when full with read=1 and write=1, accept both; use_dw stays DEPTH and no overflow is flagged.
REQ-025 SHALL, when empty with read=1 and write=1, accept only the write; use_dw becomes 1, data_out is unchanged, and underflow is flagged.
REQ-026 SHALL derive empty_n, full_n, almost_empty_n and almost_full_n from registered use_dw, so flags reflect the post-edge state with no combinational path from read or write.
REQ-027 SHALL never alter memory contents, pointers or use_dw on a rejected request.

Reset
REQ-028 SHALL, on a rising clk edge with rst_n=0, set pointers=0, use_dw=0, data_out=0, empty_n=0, full_n=1, almost_empty_n=0, almost_full_n=1, overflow=0 and underflow=0.
REQ-029 SHALL let reset take priority over read, write and err_clr in the same cycle, including while a transfer is in progress.
REQ-030 SHALL leave memory contents unreset; the contents are unobservable until rewritten.

Configuration
REQ-031 SHALL compile the error-flag logic only when macro SYNC_FIFO_ERR_FLAGS_EN is defined; overflow/underflow then set on a rejected write/read, hold until err_clr=1, and err_clr takes priority over a same-cycle set.
REQ-032 SHALL, without SYNC_FIFO_ERR_FLAGS_EN, tie overflow and underflow to 0, ignore err_clr, and keep all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, then write 0x01..0x20 on consecutive cycles (DEPTH=32) -> full_n=0 after the 32nd edge, almost_full_n=0 once use_dw=28, use_dw=32.
REQ-034 SHALL cover: full FIFO, one more write of 0xAA -> use_dw stays 32, the data is discarded, and overflow=1 (macro on) or 0 (macro off).
REQ-035 SHALL cover: read 32 times from the full FIFO -> data_out sequence 0x01..0x20, each value one cycle after its read, empty_n=0 after the last read, and the pointers wrapped to 0.
REQ-036 SHALL cover: full FIFO with read and write held together for 10 cycles -> use_dw=32 throughout, reads return FIFO order, and no overflow.
REQ-037 SHALL cover: empty FIFO with read=1 and write=1 on data 0x55 -> use_dw=1, data_out unchanged, and underflow=1 (macro on); err_clr for one cycle -> underflow=0.
REQ-038 SHALL cover: rst_n=0 asserted mid-stream with use_dw=17 -> after that edge use_dw=0, empty_n=0, data_out=0, and flags cleared.
